// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial unsigned subtractor. It computes (a - b) mod 2^WIDTH one bit per
// clock, LSB first, with a single full-subtractor cell. The cell is two hs
// half-subtractors plus an OR gate.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset
//   start  : request an operation (looked at only in IDLE or DONE)
//   a, b   : minuend / subtrahend, captured on the accepting edge
//   busy   : high while the operation is in progress
//   done   : one-cycle pulse, diff/borrow valid
//   diff   : (a - b) mod 2^WIDTH, held until the next completion
//   borrow : final borrow-out (a < b unsigned), held with diff
// ---------------------------------------------------------------------------

// Half subtractor: diff = a - b for one bit, borrow when b > a.
module hs (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b;
    assign borrow = ~a & b;
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             bq_q, bq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d1, b1, d2, b2;
    logic [WIDTH-1:0] sr_shift;

    // Full-subtractor cell: the first stage subtracts the operand bits, the
    // second stage subtracts the incoming borrow from that partial difference.
    hs u_hs1 (.a(sa_q[0]), .b(sb_q[0]), .diff(d1), .borrow(b1));
    hs u_hs2 (.a(d1),      .b(bq_q),    .diff(d2), .borrow(b2));

    // Result register shifted right with the new bit entering at the MSB.
    // Written as shift-then-overwrite so WIDTH=1 needs no empty slice.
    always_comb begin
        sr_shift            = sr_q >> 1;
        sr_shift[WIDTH-1]   = d2;
    end

    // Next-state and datapath update. DONE accepts a new start exactly like
    // IDLE, which gives back-to-back operation with no idle gap.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        bq_d     = bq_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    sr_d    = '0;
                    bq_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_shift;
                bq_d  = b1 | b2;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = sr_shift;
                    borrow_d = b1 | b2;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            bq_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            bq_q     <= bq_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Drives a WIDTH=8 and a WIDTH=1 instance of serial_sub_ctrl. Expected
// results come from plain arithmetic ((a - b) mod 2^W, a < b) and expected
// timing from the fixed latency of W busy cycles followed by one done cycle.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8;
   logic [7:0] a8, b8;
   logic       busy8, done8, borrow8;
   logic [7:0] diff8;

   logic       start1;
   logic [0:0] a1, b1;
   logic       busy1, done1, borrow1;
   logic [0:0] diff1;

   int checks = 0;
   int errors = 0;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_sub_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One WIDTH=8 operation from a one-cycle start. Optionally pulses start
   // with different operands in the third RUN cycle, which must be ignored.
   task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                                input bit midStart);
      logic [7:0] expDiff;
      logic       expBorrow;
      int         busyCount;
      expDiff   = opA - opB;
      expBorrow = (opA < opB);
      busyCount = 0;
      @(negedge clk);
      a8 = opA; b8 = opB; start8 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (midStart && k == 2) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
         end else begin
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         end
         if (busy8 && !done8) busyCount++;
      end
      checkOutput("busy_cycles", busyCount, 8);
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("done_pulse", {busy8, done8}, 2'b01);
      checkOutput("diff", diff8, expDiff);
      checkOutput("borrow", borrow8, expBorrow);
      @(negedge clk);
      checkOutput("done_cleared", {busy8, done8}, 2'b00);
      checkOutput("diff_hold", {borrow8, diff8}, {expBorrow, expDiff});
   endtask

   // One WIDTH=1 operation: a single busy cycle, then done.
   task automatic runWidth1(input logic opA, input logic opB);
      logic [1:0] wide;
      wide = {1'b0, opA} - {1'b0, opB};
      @(negedge clk);
      a1 = opA; b1 = opB; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checkOutput("w1_busy", {busy1, done1}, 2'b10);
      @(negedge clk);
      checkOutput("w1_done", {busy1, done1}, 2'b01);
      checkOutput("w1_result", {borrow1, diff1}, {wide[1], wide[0]});
   endtask

   initial begin
      int  busyCount;
      bit  sawDone;
      logic [7:0] ra, rb;

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_w8", {busy8, done8, borrow8, diff8}, 11'd0);
      checkOutput("reset_w1", {busy1, done1, borrow1, diff1}, 4'd0);
      rst = 1'b0;

      $display("[TB] basic and corner operands");
      applyStimulus(8'h5A, 8'h3C, 1'b0);
      applyStimulus(8'h00, 8'h01, 1'b0);
      applyStimulus(8'hA5, 8'hA5, 1'b0);

      $display("[TB] start ignored while running");
      applyStimulus(8'h10, 8'h01, 1'b1);

      $display("[TB] reset in the middle of an operation");
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      checkOutput("pre_reset_busy", busy8, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_outputs", {busy8, done8, borrow8, diff8}, 11'd0);
      sawDone = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done8 || busy8) sawDone = 1'b1;
      end
      checkOutput("no_done_after_abort", sawDone, 1'b0);
      applyStimulus(8'hF0, 8'h0F, 1'b0);

      $display("[TB] back-to-back with start held");
      @(negedge clk);
      a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
      busyCount = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
         if (busy8) busyCount++;
      end
      @(negedge clk);
      checkOutput("b2b_first_done", {busyCount[3:0], done8}, {4'd8, 1'b1});
      checkOutput("b2b_first_res", {borrow8, diff8}, {1'b1, 8'hFE});
      a8 = 8'h80; b8 = 8'h7F;
      busyCount = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) start8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         if (busy8) busyCount++;
      end
      @(negedge clk);
      checkOutput("b2b_second_done", {busyCount[3:0], done8}, {4'd8, 1'b1});
      checkOutput("b2b_second_res", {borrow8, diff8}, {1'b0, 8'h01});

      $display("[TB] randomized operands");
      for (int n = 0; n < 40; n++) begin
         ra = 8'($urandom);
         rb = (n % 5 == 0) ? ra : 8'($urandom);
         applyStimulus(ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("[TB] WIDTH=1 corner");
      runWidth1(1'b0, 1'b0);
      runWidth1(1'b0, 1'b1);
      runWidth1(1'b1, 1'b0);
      runWidth1(1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
